four_bit_carry_adder: RTL and testbench
=======================================

Name:
four_bit_carry_adder

Overview:
- Registered N-bit binary adder with carry-in and carry-out; default width 4.
- Computes {cout, sum} = a + b + cin as a ripple chain of full-adder cells.
- Results are captured in an output register, so they appear one clock after the operands are presented.
- Used as a basic arithmetic leaf cell in datapaths needing a carry chain and a signed-overflow indication.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal values are 1 to 32.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, reset, synchronous and active-high.
- a, input, WIDTH, operand A (unsigned; also interpreted as two's complement for the overflow flag).
- b, input, WIDTH, operand B.
- cin, input, 1, carry into bit 0.
- in_valid, input, 1, operands valid this cycle.
- sum, output, WIDTH, registered sum bits.
- cout, output, 1, registered carry out of the MSB.
- overflow, output, 1, registered signed-overflow flag.
- out_valid, output, 1, registered result-valid flag.

Behaviour:
- Arithmetic:
  - {cout, sum} = a + b + cin, computed at WIDTH+1 bits; no saturation.
  - Carry chain: c[0] = cin; for each bit i, s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]; cout = c[WIDTH].
  - overflow = c[WIDTH] ^ c[WIDTH-1]. This equals 1 when a and b share a sign bit that differs from the sum's sign bit.
- Timing:
  - On each rising clk edge with rst=0 and in_valid=1, sum, cout and overflow load the combinational result, and out_valid <= 1.
  - Latency is exactly 1 cycle; throughput is one operation per cycle, with no back-pressure.
- in_valid=0 at an edge:
  - sum, cout and overflow hold their previous values.
  - out_valid <= 0.
- Reset:
  - rst=1 at an edge forces sum=0, cout=0, overflow=0, out_valid=0, regardless of in_valid.
  - Reset asserted mid-stream discards the result for that edge.
  - The first valid result after rst deasserts appears one cycle after the first in_valid=1 edge.
- Wrap-around: results above 2^WIDTH-1 wrap modulo 2^WIDTH in sum, with cout=1.
- Outputs before the first reset are undefined; the bench must assert rst for at least one edge before checking.
- X/Z on a or b while in_valid=1 is not required to be handled.

Test Plan:
- Reset: rst=1 for 2 edges with in_valid=1, a=4'hF, b=4'hF -> sum=0, cout=0, overflow=0, out_valid=0.
- Doubling sequence, one per cycle with cin=0: (0,0), (1,1), (2,2), (3,3) -> one cycle later sum = 0, 2, 4, 6, with cout=0 and out_valid=1 for each.
- Carry-in: a=4, b=4, cin=1 -> sum=4'b1001, cout=0, overflow=1 (4 + 4 + 1 = +9 overflows signed 4-bit range).
- Wrap: a=4'hF, b=4'h1, cin=0 -> sum=0, cout=1, overflow=0. Then a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1, overflow=0.
- Hold and reset interplay:
  - in_valid=0 for 3 cycles after a result of 6 -> sum stays 6 and out_valid=0.
  - Then rst=1 with in_valid=1 (a=7, b=7) -> outputs clear.
  - Release rst, keep in_valid=1 -> sum=4'hE, cout=0, overflow=1 one cycle later.
- Exhaustive check at WIDTH=4: all 512 combinations of (a, b, cin), back-to-back -> each result matches the reference sum exactly 1 cycle later, with out_valid continuously 1.

Source files
------------

// File: rtl/four_bit_carry_adder_if.sv
// Operand/result bundle for four_bit_carry_adder.
//   a, b      : operands (unsigned; two's complement for the overflow flag)
//   cin       : carry into bit 0
//   in_valid  : operands valid this cycle
//   sum       : registered sum bits
//   cout      : registered carry out of the MSB
//   overflow  : registered signed-overflow flag
//   out_valid : registered result-valid flag
// master drives operands and observes results; slave is the adder.
interface four_bit_carry_adder_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, overflow, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, overflow, out_valid
  );
endinterface

// File: rtl/four_bit_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-in, carry-out and
// signed-overflow flag. Result appears one clock after the operands.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (clears all outputs)
//   bus : operand/result bundle (slave side)
module four_bit_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  four_bit_carry_adder_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_comb[i]  = bus.a[i] ^ bus.b[i] ^ carry[i];
    assign carry[i+1]   = (bus.a[i] & bus.b[i]) |
                          (bus.a[i] & carry[i]) |
                          (bus.b[i] & carry[i]);
  end

  // Result registers hold when no operands arrive; only the valid flag drops.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = sum_comb;
      cout_d  = carry[WIDTH];
      // Carry into and out of the sign bit disagree exactly on signed overflow.
      ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_four_bit_carry_adder.sv
module tb_four_bit_carry_adder;
  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk;
  logic rst;
  four_bit_carry_adder_if #(.WIDTH(WIDTH)) ifc ();

  four_bit_carry_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb_q[$];

  // architectural model of the output registers
  res_t m_res;
  logic m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
    res_t r;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Drive one cycle of stimulus (called just after a negedge), clock it in,
  // then check outputs at the following negedge.
  task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic v, input logic r);
    res_t exp;
    ifc.a        = a;
    ifc.b        = b;
    ifc.cin      = cin;
    ifc.in_valid = v;
    rst          = r;
    if (v && !r) sb_q.push_back(ref_add(a, b, cin));
    @(posedge clk);
    if (r) begin
      m_res   = '0;
      m_valid = 1'b0;
    end else begin
      if (v) m_res = ref_add(a, b, cin);
      m_valid = v;
    end
    @(negedge clk);
    chk("out_valid", {31'd0, ifc.out_valid}, {31'd0, m_valid});
    chk("sum",       {28'd0, ifc.sum},       {28'd0, m_res.sum});
    chk("cout",      {31'd0, ifc.cout},      {31'd0, m_res.cout});
    chk("overflow",  {31'd0, ifc.overflow},  {31'd0, m_res.ovf});
    if (ifc.out_valid) begin
      chk("sb_latency", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        chk("sb_result", {26'd0, ifc.sum, ifc.cout, ifc.overflow},
            {26'd0, exp.sum, exp.cout, exp.ovf});
      end
    end else begin
      chk("sb_idle", sb_q.size(), 0);
    end
    sb_q.delete();
  endtask

  initial begin
    m_res   = '0;
    m_valid = 1'b0;
    rst          = 1'b1;
    ifc.a        = '0;
    ifc.b        = '0;
    ifc.cin      = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);

    // reset with operands applied
    step(4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
    step(4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
    chk("rst_sum", {28'd0, ifc.sum}, 32'd0);
    chk("rst_valid", {31'd0, ifc.out_valid}, 32'd0);

    // doubling sequence
    for (int i = 0; i < 4; i++) begin
      step(WIDTH'(i), WIDTH'(i), 1'b0, 1'b1, 1'b0);
      chk("double_sum", {28'd0, ifc.sum}, 32'(2 * i));
    end

    // carry-in with signed overflow: 4+4+1 = 9
    step(4'd4, 4'd4, 1'b1, 1'b1, 1'b0);
    chk("cin_sum", {28'd0, ifc.sum}, 32'd9);
    chk("cin_ovf", {31'd0, ifc.overflow}, 32'd1);

    // wrap-around
    step(4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
    chk("wrap_sum", {28'd0, ifc.sum}, 32'd0);
    chk("wrap_cout", {31'd0, ifc.cout}, 32'd1);
    step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
    chk("wrap2_sum", {28'd0, ifc.sum}, 32'hF);
    chk("wrap2_ovf", {31'd0, ifc.overflow}, 32'd0);

    // hold after a result of 6
    step(4'd3, 4'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'hA, 4'h5, 1'b1, 1'b0, 1'b0);
      chk("hold_sum", {28'd0, ifc.sum}, 32'd6);
    end

    // reset mid-stream discards the result, then recovery
    step(4'd7, 4'd7, 1'b0, 1'b1, 1'b1);
    chk("midrst_sum", {28'd0, ifc.sum}, 32'd0);
    step(4'd7, 4'd7, 1'b0, 1'b1, 1'b0);
    chk("post_rst_sum", {28'd0, ifc.sum}, 32'hE);
    chk("post_rst_ovf", {31'd0, ifc.overflow}, 32'd1);

    // exhaustive, back-to-back
    for (int ci = 0; ci < 2; ci++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          step(WIDTH'(ia), WIDTH'(ib), ci[0], 1'b1, 1'b0);

    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
